part_sweep_meter: RTL and testbench
===================================

# part_sweep_meter

Exhaustive-sweep error meter for a combinational approximate partition of the MAC design. It drives every input pattern of a NI-input / NO-output partition to an exact and an approximate instance in parallel. After a settle interval it samples both output buses and accumulates error metrics. It sits directly downstream of the partition pair and consumes their outputs. It is the synthesizable replacement for the display-based exhaustive testbench, and it additionally streams each sampled approximate output for truth-table capture.

## Interface
Parameters:
- NI, 5, partition input count; sweep covers 2^NI patterns
- NO, 3, partition output count
- SETTLE, 1, hold cycles after a pattern is applied before it is sampled; legal range ≥1

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin sweep; honoured only in IDLE
- abort  in  1  cancel sweep; return to IDLE
- pi_o  out  NI  pattern driven to both partitions; pi_o[NI-1] maps to the partition's first input
- po_exact  in  NO  exact partition output
- po_approx  in  NO  approximate partition output
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse when the sweep completes
- res_valid  out  1  metrics below are complete
- err_cnt  out  NI+1  number of patterns where po_exact != po_approx
- max_abs_err  out  NO  maximum of |po_exact - po_approx| (unsigned)
- sum_abs_err  out  NO+NI  sum of |po_exact - po_approx|
- ham_sum  out  NI+$clog2(NO+1)  sum of popcount(po_exact ^ po_approx)
- cap_valid  out  1  one-cycle strobe per sampled pattern
- cap_idx  out  NI  pattern index of the current capture
- cap_po  out  NO  po_approx value at the sample

## Operation
- States: IDLE, HOLD, SAMPLE, DONE.
- IDLE: pi_o=0, busy=0. If start=1 and abort=0:
  - clear all accumulators and res_valid
  - zero the index and the settle counter
  - go to HOLD
- HOLD: pi_o=index. The settle counter counts SETTLE cycles, then the FSM goes to SAMPLE.
- SAMPLE (pi_o still equal to index):
  - compare both buses and update all four metrics
  - pulse cap_valid with cap_idx=index and cap_po=po_approx
  - if index=2^NI-1, go to DONE; otherwise increment index and return to HOLD
- DONE: done=1 and res_valid set, both for one cycle; busy stays 1 in that cycle; the FSM then goes to IDLE.
- Arithmetic:
  - abs error is computed in unsigned NO+1 bits
  - accumulators are sized so they never overflow at full sweep, so no saturation logic exists
- Metrics and res_valid hold their values in IDLE until the next accepted start.
- start while not IDLE is ignored.
- abort has priority over start and over every state transition:
  - the next state is IDLE; no done is produced
  - res_valid is cleared; accumulators hold their partial values
  - cap_valid is suppressed in the abort cycle
- Reset (rst_n=0 at an edge, in any state including mid-sweep):
  - FSM returns to IDLE
  - all outputs and accumulators return to 0
  - pi_o is 0 on the next cycle

## Timing
- Reset values: pi_o, busy, done, res_valid, err_cnt, max_abs_err, sum_abs_err, ham_sum, cap_valid, cap_idx, cap_po are all 0.
- start is sampled at edge E. busy=1 and pi_o=0 take effect from E+1.
- Each pattern occupies SETTLE+1 cycles: SETTLE HOLD cycles, then 1 SAMPLE cycle.
- Pattern i is sampled in cycle E+(i+1)(SETTLE+1).
- done is high in cycle E+2^NI(SETTLE+1)+1. With the defaults this is E+65.
- busy falls in the cycle after done.
- The partition is purely combinational; po_* must be stable within SETTLE cycles of a pi_o change.
- Accumulator updates take effect one cycle after SAMPLE, so they are final before done.

## Test plan
- Identical exact and approx model (both return pi[2:0]), defaults:
  - done at E+65; err_cnt=0, max=0, sum=0, ham=0, res_valid=1
  - 32 cap_valid strobes with cap_idx 0..31 in order
- Exact=pi[2:0], approx=0:
  - err_cnt=28, max_abs_err=7, sum_abs_err=112, ham_sum=48
- Approx = exact ^ 3'b100 only at pattern 13:
  - err_cnt=1, max_abs_err=4, sum_abs_err=4, ham_sum=1
  - cap_po at idx 13 differs from exact
- abort asserted together with the 10th cap_valid:
  - no done; res_valid=0; busy=0 next cycle
  - a following start produces a clean full result identical to the reference run
- start pulsed repeatedly while busy: the sweep timing is unchanged, with exactly one done at E+65.
- rst_n low at the 20th cycle of a sweep:
  - all outputs are 0 on the next cycle; the FSM is in IDLE
  - start then completes normally with SETTLE=2: done at E+97

Source files
------------

// File: rtl/part_sweep_meter.sv
// part_sweep_meter: drives every pattern to an exact/approximate partition
// pair, accumulates error metrics and streams each sampled approx output.
module part_sweep_meter #(
  parameter int NI     = 5,
  parameter int NO     = 3,
  parameter int SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic [NI-1:0]             pi_o,
  input  logic [NO-1:0]             po_exact,
  input  logic [NO-1:0]             po_approx,
  output logic                      busy,
  output logic                      done,
  output logic                      res_valid,
  output logic [NI:0]               err_cnt,
  output logic [NO-1:0]             max_abs_err,
  output logic [NO+NI-1:0]          sum_abs_err,
  output logic [NI+$clog2(NO+1)-1:0] ham_sum,
  output logic                      cap_valid,
  output logic [NI-1:0]             cap_idx,
  output logic [NO-1:0]             cap_po
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = $clog2(NO + 1);
  localparam int HW = NI + PW;
  localparam logic [NI-1:0] LAST = '1;
  localparam logic [SW-1:0] CMAX = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t st, nxt;

  logic [NI-1:0] idx;
  logic [SW-1:0] cnt;
  logic [NO:0]   ex_w, ap_w, ad;
  logic [NO-1:0] xd;
  logic [PW-1:0] pc;
  logic          smp;

  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE:   if (start) nxt = S_HOLD;
      S_HOLD:   if (cnt == CMAX) nxt = S_SAMPLE;
      S_SAMPLE: nxt = (idx == LAST) ? S_DONE : S_HOLD;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  always_comb begin
    smp       = (st == S_SAMPLE);
    busy      = (st != S_IDLE);
    done      = (st == S_DONE) && !abort;
    pi_o      = (st == S_HOLD || smp) ? idx : '0;
    cap_valid = smp && !abort;
    cap_idx   = cap_valid ? idx : '0;
    cap_po    = cap_valid ? po_approx : '0;
  end

  // abs error in NO+1 bits, so the subtraction never wraps
  always_comb begin
    ex_w = {1'b0, po_exact};
    ap_w = {1'b0, po_approx};
    ad   = (ex_w >= ap_w) ? ex_w - ap_w : ap_w - ex_w;
    xd   = po_exact ^ po_approx;
    pc   = '0;
    for (int i = 0; i < NO; i++) pc = pc + PW'(xd[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      res_valid   <= 1'b0;
      err_cnt     <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
      ham_sum     <= '0;
    end else begin
      st <= nxt;
      if (abort) begin
        res_valid <= 1'b0;
      end else begin
        unique case (st)
          S_IDLE: if (start) begin
            idx         <= '0;
            cnt         <= '0;
            res_valid   <= 1'b0;
            err_cnt     <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
            ham_sum     <= '0;
          end
          S_HOLD: cnt <= (cnt == CMAX) ? '0 : cnt + SW'(1);
          S_SAMPLE: begin
            err_cnt     <= err_cnt + (NI+1)'(|xd);
            sum_abs_err <= sum_abs_err + (NO+NI)'(ad);
            ham_sum     <= ham_sum + HW'(pc);
            if (ad > {1'b0, max_abs_err})
              max_abs_err <= ad[NO-1:0];
            if (idx != LAST) idx <= idx + NI'(1);
            else res_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_part_sweep_meter.sv
// tb_part_sweep_meter: table vectors, random truth tables vs a
// metric model, plus abort / restart / reset / SETTLE=2 sequences.
module tb_part_sweep_meter;
  localparam int NI = 5;
  localparam int NO = 3;
  localparam int HW = NI + $clog2(NO + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0;
  logic start1 = 1'b0, abort1 = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] pi0, pi1, cidx0, cidx1;
  logic [NO-1:0] ex0, ap0, ex1, ap1;
  logic [NO-1:0] max0, max1, cpo0, cpo1;
  logic busy0, done0, res0, cv0;
  logic busy1, done1, res1, cv1;
  logic [NI:0] err0, err1;
  logic [NO+NI-1:0] sum0, sum1;
  logic [HW-1:0] ham0, ham1;

  int total = 0;
  int bad = 0;
  int mode;
  int ex_tab[32], ap_tab[32];
  int m_ex[32], m_ap[32];
  int r_err, r_max, r_sum, r_ham;

  // partition pair: truth tables filled by the model
  always_comb begin
    ex0 = 3'(m_ex[pi0]);
    ap0 = 3'(m_ap[pi0]);
    ex1 = 3'(m_ex[pi1]);
    ap1 = 3'(m_ap[pi1]);
  end

  part_sweep_meter #(.NI(NI), .NO(NO), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .pi_o(pi0), .po_exact(ex0), .po_approx(ap0),
    .busy(busy0), .done(done0), .res_valid(res0),
    .err_cnt(err0), .max_abs_err(max0), .sum_abs_err(sum0),
    .ham_sum(ham0), .cap_valid(cv0), .cap_idx(cidx0), .cap_po(cpo0)
  );

  part_sweep_meter #(.NI(NI), .NO(NO), .SETTLE(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .pi_o(pi1), .po_exact(ex1), .po_approx(ap1),
    .busy(busy1), .done(done1), .res_valid(res1),
    .err_cnt(err1), .max_abs_err(max1), .sum_abs_err(sum1),
    .ham_sum(ham1), .cap_valid(cv1), .cap_idx(cidx1), .cap_po(cpo1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic model_fill();
    r_err = 0; r_max = 0; r_sum = 0; r_ham = 0;
    for (int p = 0; p < 32; p++) begin
      int e, a, d;
      e = p % 8;
      a = e;
      case (mode)
        1: a = 0;
        2: if (p == 13) a = e ^ 4;
        3: begin e = ex_tab[p]; a = ap_tab[p]; end
        default: ;
      endcase
      m_ex[p] = e;
      m_ap[p] = a;
      d = (e > a) ? e - a : a - e;
      if (d != 0) r_err++;
      if (d > r_max) r_max = d;
      r_sum += d;
      r_ham += $countones(e ^ a);
    end
  endtask

  int o_done_cyc, o_done_n, o_cap_n;
  int o_order_bad, o_po_bad, o_busy_bad;
  logic [63:0] o_err, o_max, o_sum, o_ham, o_res;
  logic [63:0] o_busy_after, o_res_after, o_err_after;

  task automatic sweep0(input bit rep, input int abort_cap);
    int ev;
    ev = -1;
    o_done_cyc = -1; o_done_n = 0; o_cap_n = 0;
    o_order_bad = 0; o_po_bad = 0; o_busy_bad = 0;
    o_err = '1; o_max = '1; o_sum = '1; o_ham = '1; o_res = '1;
    o_busy_after = '1; o_res_after = '1; o_err_after = '1;
    @(negedge clk);
    start0 = 1'b1;
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      if (n == ev + 1) begin
        o_busy_after = 64'(busy0);
        o_res_after  = 64'(res0);
        o_err_after  = 64'(err0);
        abort0 = 1'b0;
      end
      start0 = (rep && n < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (abort_cap == 0 && busy0 !== (n <= 65)) o_busy_bad++;
      if (done0) begin
        o_done_n++;
        if (o_done_cyc < 0) begin
          o_done_cyc = n; ev = n;
          o_err = 64'(err0); o_max = 64'(max0);
          o_sum = 64'(sum0); o_ham = 64'(ham0);
          o_res = 64'(res0);
        end
      end
      if (cv0) begin
        if (cidx0 !== NI'(o_cap_n)) o_order_bad++;
        if (int'(cpo0) != m_ap[cidx0]) o_po_bad++;
        o_cap_n++;
        if (o_cap_n == abort_cap) begin
          abort0 = 1'b1;
          ev = n;
        end
      end
    end
    abort0 = 1'b0;
  endtask

  task automatic chk_full(input string nm, input int e, input int mx,
                          input int s, input int h);
    chk({nm, "_done_cyc"}, o_done_cyc, 65);
    chk({nm, "_done_n"}, o_done_n, 1);
    chk({nm, "_cap_n"}, o_cap_n, 32);
    chk({nm, "_cap_order"}, o_order_bad, 0);
    chk({nm, "_cap_po"}, o_po_bad, 0);
    chk({nm, "_busy"}, o_busy_bad, 0);
    chk({nm, "_err"}, o_err, e);
    chk({nm, "_max"}, o_max, mx);
    chk({nm, "_sum"}, o_sum, s);
    chk({nm, "_ham"}, o_ham, h);
    chk({nm, "_res"}, o_res, 1);
    chk({nm, "_busy_after"}, o_busy_after, 0);
    chk({nm, "_res_hold"}, o_res_after, 1);
    chk({nm, "_err_hold"}, o_err_after, e);
  endtask

  typedef struct {
    int mode;
    int err;
    int max;
    int sum;
    int ham;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int d1_cyc, d1_n, c1_n;
    logic [63:0] e1, m1, s1, h1;
    vecs[0] = '{mode: 0, err: 0,  max: 0, sum: 0,   ham: 0};
    vecs[1] = '{mode: 1, err: 28, max: 7, sum: 112, ham: 48};
    vecs[2] = '{mode: 2, err: 1,  max: 4, sum: 4,   ham: 1};

    mode = 0;
    model_fill();
    repeat (2) @(negedge clk);
    chk("rst_pi", pi0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_res", res0, 0);
    chk("rst_metrics", {err0, max0, sum0, ham0}, 0);
    chk("rst_cap", {cv0, cidx0, cpo0}, 0);
    chk("rst_u1", {busy1, done1, res1, err1, cv1, pi1}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      mode = vecs[v].mode;
      model_fill();
      sweep0(1'b0, 0);
      chk_full($sformatf("vec%0d", v), vecs[v].err, vecs[v].max,
               vecs[v].sum, vecs[v].ham);
    end

    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 32; p++) begin
        ex_tab[p] = int'($urandom_range(0, 7));
        ap_tab[p] = ($urandom_range(0, 2) == 0) ?
                    int'($urandom_range(0, 7)) : ex_tab[p];
      end
      mode = 3;
      model_fill();
      sweep0(1'b0, 0);
      chk_full($sformatf("rand%0d", r), r_err, r_max, r_sum, r_ham);
    end

    mode = 1;
    model_fill();
    sweep0(1'b0, 10);
    chk("abort_done_n", o_done_n, 0);
    chk("abort_cap_n", o_cap_n, 10);
    chk("abort_busy", o_busy_after, 0);
    chk("abort_res", o_res_after, 0);
    sweep0(1'b0, 0);
    chk_full("after_abort", 28, 7, 112, 48);

    mode = 2;
    model_fill();
    sweep0(1'b1, 0);
    chk_full("rep_start", 1, 4, 4, 1);

    mode = 1;
    model_fill();
    @(negedge clk);
    start0 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_pi", pi0, 0);
    chk("mid_rst_out", {done0, res0, cv0, cidx0, cpo0}, 0);
    chk("mid_rst_met", {err0, max0, sum0, ham0}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    d1_cyc = -1; d1_n = 0; c1_n = 0;
    e1 = '1; m1 = '1; s1 = '1; h1 = '1;
    start1 = 1'b1;
    for (int n = 1; n <= 105; n++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (cv1) c1_n++;
      if (done1) begin
        d1_n++;
        if (d1_cyc < 0) begin
          d1_cyc = n;
          e1 = 64'(err1); m1 = 64'(max1);
          s1 = 64'(sum1); h1 = 64'(ham1);
        end
      end
    end
    chk("s2_done_cyc", d1_cyc, 97);
    chk("s2_done_n", d1_n, 1);
    chk("s2_cap_n", c1_n, 32);
    chk("s2_err", e1, 28);
    chk("s2_max", m1, 7);
    chk("s2_sum", s1, 112);
    chk("s2_ham", h1, 48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
